// File: rtl/breath_ramp_gen.sv
// breath_ramp_gen: trapezoidal brightness profile for the breathing-LED PWM.
// Each prescaled step tick advances the profile by one step and offers the new
// duty value downstream on a valid/ready handshake. One blocked step is
// buffered; any further blocked tick is dropped and latches the overrun flag.
//
//   phase   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | disabled, prescaler stopped, level parked at 0
//   RISE    | level climbs by STEP per step, saturating at DUTY_MAX
//   HOLD_HI | dwell at DUTY_MAX for HOLD_STEPS steps
//   FALL    | level drops by STEP per step, floored at 0
//   HOLD_LO | dwell at 0 for HOLD_STEPS steps
module breath_ramp_gen #(
  parameter int DIV_FACTOR = 2400,
  parameter int DUTY_W     = 8,
  parameter int DUTY_MAX   = 100,
  parameter int STEP       = 1,
  parameter int HOLD_STEPS = 0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              duty_ready,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid,
  output logic [2:0]        phase,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } phase_t;

  localparam int CNT_W  = $clog2(DIV_FACTOR);
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV_FACTOR - 1);
  localparam logic [DUTY_W:0]   MAX_EXT   = (DUTY_W + 1)'(DUTY_MAX);
  localparam logic [DUTY_W:0]   STEP_EXT  = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W-1:0] MAX_V     = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] STEP_V    = DUTY_W'(STEP);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

  phase_t              phase_q, phase_n;
  logic [DUTY_W-1:0]   level_q, level_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [HOLD_W-1:0]   hold_q, hold_n;
  logic                pend_q, pend_n;
  logic                dark_q, dark_n;
  logic [DUTY_W-1:0]   duty_q, duty_n;
  logic                valid_q, valid_n;
  logic                overrun_q, overrun_n;

  logic                slot_free;
  logic                accept;
  logic                tick;
  logic                step;
  logic [DUTY_W:0]     rise_sum;
  logic                fall_floor;
  logic [DUTY_W-1:0]   fall_diff;

  assign slot_free  = !valid_q || duty_ready;
  assign accept     = valid_q && duty_ready;
  assign tick       = (phase_q != IDLE) && (cnt_q == CNT_LAST);
  // Saturation is judged one bit wider so level+STEP cannot wrap past DUTY_W.
  assign rise_sum   = {1'b0, level_q} + STEP_EXT;
  assign fall_floor = ({1'b0, level_q} <= STEP_EXT);
  assign fall_diff  = level_q - STEP_V;

  // Next-state logic: disable request, idle handshake drain, or running profile.
  always_comb begin
    phase_n   = phase_q;
    level_n   = level_q;
    cnt_n     = cnt_q;
    hold_n    = hold_q;
    pend_n    = pend_q;
    dark_n    = dark_q;
    duty_n    = duty_q;
    valid_n   = valid_q;
    overrun_n = overrun_q;
    step      = 1'b0;

    if (phase_q != IDLE && !en) begin
      phase_n = IDLE;
      level_n = '0;
      cnt_n   = '0;
      hold_n  = '0;
      pend_n  = 1'b0;
      // Publish "dark" once; if the slot is still occupied, remember to do it
      // after the outstanding value is taken so duty_out never changes unseen.
      if (slot_free) begin
        duty_n  = '0;
        valid_n = 1'b1;
        dark_n  = 1'b0;
      end else begin
        dark_n  = 1'b1;
      end
    end else if (phase_q == IDLE) begin
      if (dark_q && accept) begin
        duty_n  = '0;
        valid_n = 1'b1;
        dark_n  = 1'b0;
      end else if (accept) begin
        valid_n = 1'b0;
      end
      if (en) begin
        phase_n = RISE;
        cnt_n   = '0;
        level_n = '0;
      end
    end else begin
      cnt_n = tick ? '0 : cnt_q + 1'b1;
      step  = (tick || pend_q) && slot_free;

      if (tick && !slot_free) begin
        if (pend_q) overrun_n = 1'b1;
        else        pend_n    = 1'b1;
      end

      if (step) begin
        pend_n = 1'b0;
        // A fresh step supersedes any deferred dark value.
        dark_n = 1'b0;
        case (phase_q)
          RISE: begin
            if (rise_sum >= MAX_EXT) begin
              level_n = MAX_V;
              phase_n = (HOLD_STEPS > 0) ? HOLD_HI : FALL;
            end else begin
              level_n = rise_sum[DUTY_W-1:0];
            end
          end
          HOLD_HI: begin
            if (hold_q == HOLD_LAST) begin
              hold_n  = '0;
              phase_n = FALL;
            end else begin
              hold_n  = hold_q + 1'b1;
            end
          end
          FALL: begin
            if (fall_floor) begin
              level_n = '0;
              phase_n = (HOLD_STEPS > 0) ? HOLD_LO : RISE;
            end else begin
              level_n = fall_diff;
            end
          end
          HOLD_LO: begin
            if (hold_q == HOLD_LAST) begin
              hold_n  = '0;
              phase_n = RISE;
            end else begin
              hold_n  = hold_q + 1'b1;
            end
          end
          default: ;
        endcase
        duty_n  = level_n;
        valid_n = 1'b1;
      end else if (dark_q && accept) begin
        duty_n  = '0;
        valid_n = 1'b1;
        dark_n  = 1'b0;
      end else if (accept) begin
        valid_n = 1'b0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      phase_q   <= IDLE;
      level_q   <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      pend_q    <= 1'b0;
      dark_q    <= 1'b0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      phase_q   <= phase_n;
      level_q   <= level_n;
      cnt_q     <= cnt_n;
      hold_q    <= hold_n;
      pend_q    <= pend_n;
      dark_q    <= dark_n;
      duty_q    <= duty_n;
      valid_q   <= valid_n;
      overrun_q <= overrun_n;
    end
  end

  assign duty_out   = duty_q;
  assign duty_valid = valid_q;
  assign phase      = phase_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_breath_ramp_gen.sv
// Bench for breath_ramp_gen: two instances (with and without dwell) sharing
// clock and stimulus; expected duty/phase values queued up front and popped on
// each handshake.
module tb_breath_ramp_gen;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       duty_ready = 1'b0;
  logic [7:0] duty_out, duty_out0;
  logic       duty_valid, duty_valid0;
  logic [2:0] phase, phase0;
  logic       overrun, overrun0;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] exp_duty_q[$];
  logic [2:0] exp_phase_q[$];
  logic [7:0] exp0_duty_q[$];
  logic [2:0] exp0_phase_q[$];

  logic [7:0] seq_h[13]  = '{8'd3, 8'd6, 8'd9, 8'd10, 8'd10, 8'd10, 8'd7, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0, 8'd3};
  logic [2:0] ph_h[13]   = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd1, 3'd1};
  logic [7:0] seq_0[9]   = '{8'd3, 8'd6, 8'd9, 8'd10, 8'd7, 8'd4, 8'd1, 8'd0, 8'd3};
  logic [2:0] ph_0[9]    = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd1, 3'd1};

  always #5 clk_in = ~clk_in;

  breath_ramp_gen #(.DIV_FACTOR(4), .DUTY_W(8), .DUTY_MAX(10), .STEP(3), .HOLD_STEPS(2)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .duty_ready(duty_ready),
    .duty_out(duty_out), .duty_valid(duty_valid), .phase(phase), .overrun(overrun));

  breath_ramp_gen #(.DIV_FACTOR(4), .DUTY_W(8), .DUTY_MAX(10), .STEP(3), .HOLD_STEPS(0)) dut0 (
    .clk_in(clk_in), .rst(rst), .en(en), .duty_ready(duty_ready),
    .duty_out(duty_out0), .duty_valid(duty_valid0), .phase(phase0), .overrun(overrun0));

  task automatic apply_reset;
    @(negedge clk_in);
    rst = 1'b1; en = 1'b0; duty_ready = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk_in);
    rst = 1'b1; en = 1'b1; duty_ready = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    n_total++; if (duty_out !== 8'd0) $display("FAIL reset_duty got %0d want 0", duty_out); else n_pass++;
    n_total++; if (duty_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", duty_valid); else n_pass++;
    n_total++; if (phase !== 3'd0) $display("FAIL reset_phase got %0d want 0", phase); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else n_pass++;
    n_total++; if (duty_valid0 !== 1'b0) $display("FAIL reset_valid0 got %b want 0", duty_valid0); else n_pass++;
    n_total++; if (phase0 !== 3'd0) $display("FAIL reset_phase0 got %0d want 0", phase0); else n_pass++;
    rst = 1'b0; en = 1'b0; duty_ready = 1'b0;
  endtask

  task automatic test_sequence;
    int cyc, last;
    logic [7:0] ed;
    logic [2:0] ep;
    apply_reset();
    foreach (seq_h[i]) begin exp_duty_q.push_back(seq_h[i]); exp_phase_q.push_back(ph_h[i]); end
    foreach (seq_0[i]) begin exp0_duty_q.push_back(seq_0[i]); exp0_phase_q.push_back(ph_0[i]); end
    duty_ready = 1'b1; en = 1'b1;
    cyc = 0; last = -1;
    while ((exp_duty_q.size() > 0 || exp0_duty_q.size() > 0) && cyc < 200) begin
      if (duty_valid && duty_ready && exp_duty_q.size() > 0) begin
        ed = exp_duty_q.pop_front(); ep = exp_phase_q.pop_front();
        n_total++; if (duty_out !== ed) $display("FAIL seq_duty got %0d want %0d at cyc %0d", duty_out, ed, cyc); else n_pass++;
        n_total++; if (phase !== ep) $display("FAIL seq_phase got %0d want %0d at cyc %0d", phase, ep, cyc); else n_pass++;
        if (last < 0) begin
          n_total++; if (cyc !== 5) $display("FAIL first_latency got %0d want 5", cyc); else n_pass++;
        end else begin
          n_total++; if (cyc - last !== 4) $display("FAIL step_spacing got %0d want 4", cyc - last); else n_pass++;
        end
        last = cyc;
      end
      if (duty_valid0 && duty_ready && exp0_duty_q.size() > 0) begin
        ed = exp0_duty_q.pop_front(); ep = exp0_phase_q.pop_front();
        n_total++; if (duty_out0 !== ed) $display("FAIL nohold_duty got %0d want %0d at cyc %0d", duty_out0, ed, cyc); else n_pass++;
        n_total++; if (phase0 !== ep) $display("FAIL nohold_phase got %0d want %0d at cyc %0d", phase0, ep, cyc); else n_pass++;
      end
      @(negedge clk_in); cyc++;
    end
    n_total++;
    if (exp_duty_q.size() != 0 || exp0_duty_q.size() != 0)
      $display("FAIL seq_timeout got %0d/%0d left want 0/0", exp_duty_q.size(), exp0_duty_q.size());
    else n_pass++;
    exp_duty_q.delete(); exp_phase_q.delete(); exp0_duty_q.delete(); exp0_phase_q.delete();
  endtask

  task automatic test_backpressure;
    int cyc, ov_at;
    bit stable, found;
    logic [7:0] ed;
    apply_reset();
    duty_ready = 1'b0; en = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      if (duty_valid) found = 1;
    end
    n_total++; if (!found) $display("FAIL bp_first_value got none want valid"); else n_pass++;
    n_total++; if (duty_out !== 8'd3) $display("FAIL bp_first_duty got %0d want 3", duty_out); else n_pass++;
    stable = 1; ov_at = -1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk_in);
      if (!(duty_valid === 1'b1 && duty_out === 8'd3)) stable = 0;
      if (overrun === 1'b1 && ov_at < 0) ov_at = k;
    end
    n_total++; if (stable !== 1'b1) $display("FAIL bp_hold got unstable want duty 3 valid 1"); else n_pass++;
    n_total++; if (ov_at !== 8) $display("FAIL bp_overrun_time got %0d want 8", ov_at); else n_pass++;
    exp_duty_q.push_back(8'd3); exp_duty_q.push_back(8'd6); exp_duty_q.push_back(8'd9);
    duty_ready = 1'b1;
    cyc = 0;
    while (exp_duty_q.size() > 0 && cyc < 40) begin
      if (duty_valid && duty_ready) begin
        ed = exp_duty_q.pop_front();
        n_total++; if (duty_out !== ed) $display("FAIL bp_drain got %0d want %0d", duty_out, ed); else n_pass++;
      end
      @(negedge clk_in); cyc++;
    end
    n_total++; if (exp_duty_q.size() != 0) $display("FAIL bp_timeout got %0d left want 0", exp_duty_q.size()); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL bp_overrun_sticky got %b want 1", overrun); else n_pass++;
    exp_duty_q.delete();
  endtask

  task automatic test_pulsed_ready;
    int cyc;
    bit seen;
    logic [7:0] ed;
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 6; i++) exp_duty_q.push_back(seq_h[i]);
    cyc = 0; seen = 0;
    while (exp_duty_q.size() > 0 && cyc < 200) begin
      duty_ready = ((cyc % 8) == 7);
      if (duty_valid && !seen) begin
        seen = 1;
        n_total++; if (overrun !== 1'b0) $display("FAIL pulse_overrun_early got %b want 0", overrun); else n_pass++;
      end
      if (duty_valid && duty_ready) begin
        ed = exp_duty_q.pop_front();
        n_total++; if (duty_out !== ed) $display("FAIL pulse_drain got %0d want %0d", duty_out, ed); else n_pass++;
      end
      @(negedge clk_in); cyc++;
    end
    duty_ready = 1'b0;
    n_total++; if (exp_duty_q.size() != 0) $display("FAIL pulse_timeout got %0d left want 0", exp_duty_q.size()); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL pulse_overrun got %b want 1", overrun); else n_pass++;
    exp_duty_q.delete();
  endtask

  task automatic test_en_drop;
    bit found;
    int lat;
    apply_reset();
    duty_ready = 1'b1; en = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_in);
      if (duty_valid && duty_out == 8'd7 && phase == 3'd3) found = 1;
    end
    n_total++; if (!found) $display("FAIL drop_find_fall7 got none want duty 7 in FALL"); else n_pass++;
    en = 1'b0;
    @(negedge clk_in);
    n_total++; if (phase !== 3'd0) $display("FAIL drop_phase got %0d want 0", phase); else n_pass++;
    n_total++; if (duty_out !== 8'd0) $display("FAIL drop_duty got %0d want 0", duty_out); else n_pass++;
    n_total++; if (duty_valid !== 1'b1) $display("FAIL drop_valid got %b want 1", duty_valid); else n_pass++;
    @(negedge clk_in);
    n_total++; if (duty_valid !== 1'b0) $display("FAIL drop_accepted got %b want 0", duty_valid); else n_pass++;
    en = 1'b1;
    @(negedge clk_in);
    n_total++; if (phase !== 3'd1) $display("FAIL reenable_phase got %0d want 1", phase); else n_pass++;
    lat = -1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk_in);
      if (duty_valid) lat = k;
    end
    n_total++; if (lat !== 4) $display("FAIL reenable_latency got %0d want 4", lat); else n_pass++;
    n_total++; if (duty_out !== 8'd3) $display("FAIL reenable_duty got %0d want 3", duty_out); else n_pass++;
  endtask

  task automatic test_en_drop_blocked;
    bit found;
    apply_reset();
    duty_ready = 1'b0; en = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      if (duty_valid) found = 1;
    end
    n_total++; if (!found) $display("FAIL dropb_first got none want valid"); else n_pass++;
    en = 1'b0;
    @(negedge clk_in);
    n_total++; if (duty_out !== 8'd3) $display("FAIL dropb_hold_duty got %0d want 3", duty_out); else n_pass++;
    n_total++; if (phase !== 3'd0) $display("FAIL dropb_phase got %0d want 0", phase); else n_pass++;
    duty_ready = 1'b1;
    @(negedge clk_in);
    duty_ready = 1'b0;
    n_total++; if (duty_out !== 8'd0) $display("FAIL dropb_dark_duty got %0d want 0", duty_out); else n_pass++;
    n_total++; if (duty_valid !== 1'b1) $display("FAIL dropb_dark_valid got %b want 1", duty_valid); else n_pass++;
    duty_ready = 1'b1;
    @(negedge clk_in);
    n_total++; if (duty_valid !== 1'b0) $display("FAIL dropb_final_valid got %b want 0", duty_valid); else n_pass++;
  endtask

  task automatic test_rst_mid;
    bit found;
    apply_reset();
    duty_ready = 1'b0; en = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      if (duty_valid) found = 1;
    end
    repeat (12) @(negedge clk_in);
    n_total++; if (overrun !== 1'b1) $display("FAIL rstmid_pre_overrun got %b want 1", overrun); else n_pass++;
    n_total++; if (duty_valid !== 1'b1) $display("FAIL rstmid_pre_valid got %b want 1", duty_valid); else n_pass++;
    rst = 1'b1;
    @(negedge clk_in);
    n_total++; if (duty_out !== 8'd0) $display("FAIL rstmid_duty got %0d want 0", duty_out); else n_pass++;
    n_total++; if (duty_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", duty_valid); else n_pass++;
    n_total++; if (phase !== 3'd0) $display("FAIL rstmid_phase got %0d want 0", phase); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL rstmid_overrun got %b want 0", overrun); else n_pass++;
    rst = 1'b0; en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_pulsed_ready();
    test_en_drop();
    test_en_drop_blocked();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/breath_ramp_gen.md
# breath_ramp_gen

Brightness-profile generator feeding the PWM output stage of the breathing-LED path. Produces a periodic trapezoidal duty sequence (rise, dwell high, fall, dwell low) at a prescaled step rate and hands each new duty value downstream over a valid/ready handshake. The PWM stage asserts ready once per PWM period, so duty changes land only on period boundaries. A sticky overrun flag reports dropped steps when the consumer is too slow.

## Interface
- DIV_FACTOR, 2400: clk_in cycles per step tick (≥2)
- DUTY_W, 8: duty width in bits
- DUTY_MAX, 100: peak duty value (1..2^DUTY_W−1)
- STEP, 1: duty increment/decrement per step (1..DUTY_MAX)
- HOLD_STEPS, 0: steps spent at peak and at trough (0 = no dwell)

- clk_in  in  1  system clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- en  in  1  run enable
- duty_ready  in  1  consumer accepts duty_out this cycle
- duty_out  out  DUTY_W  duty value offered to the PWM stage
- duty_valid  out  1  duty_out is valid
- phase  out  3  IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4
- overrun  out  1  sticky: a step tick was lost

## Operation
- Reset: duty_out=0, duty_valid=0, phase=IDLE, overrun=0. Internal state also clears: level=0, prescaler=0, pend=0, hold count=0.
- Prescaler counts 0..DIV_FACTOR−1 only while phase≠IDLE. tick = (count==DIV_FACTOR−1).
- slot_free = !duty_valid || duty_ready.
- step = (tick || pend) && slot_free.
- On tick && !slot_free: if pend=0, set pend; if pend=1, set overrun.
- pend clears on step.
- On step, per phase:
  - RISE: level = min(level+STEP, DUTY_MAX), computed in DUTY_W+1 bits. On reaching DUTY_MAX, go to HOLD_HI, or to FALL if HOLD_STEPS=0.
  - HOLD_HI: level unchanged; hold count+1. After HOLD_STEPS steps, go to FALL and clear the count.
  - FALL: level = (level<STEP) ? 0 : level−STEP. On reaching 0, go to HOLD_LO, or to RISE if HOLD_STEPS=0.
  - HOLD_LO: mirror of HOLD_HI, then go to RISE.
- Every step loads duty_out with the new level and sets duty_valid=1.
- Accept (duty_valid && duty_ready) with no step in the same cycle clears duty_valid next cycle.
- IDLE with en=1: next cycle phase=RISE, prescaler=0, level=0.
- en=0 while not IDLE (checked every cycle, highest priority after rst): next cycle:
  - phase=IDLE, level=0, pend=0, prescaler=0, hold count=0.
  - If slot_free: duty_out=0 and duty_valid=1, publishing dark once.
  - Else: the pending value is held until accepted, then duty_out=0 and duty_valid=1 are loaded.
- IDLE with en=0: no new values; an outstanding value stays offered until accepted.
- overrun clears only on rst.

## Timing
- Step in cycle t → duty_out/duty_valid updated at t+1.
- The first tick after entering RISE occurs DIV_FACTOR cycles after the RISE entry cycle.
- duty_out is stable while duty_valid && !duty_ready. It never changes without a handshake or reset.
- At most one pending step is buffered. A second tick while blocked is dropped and flagged.
- Simultaneous accept and step: the new value is loaded and duty_valid stays 1.
- rst mid-sequence: all outputs return to reset values at the next edge, regardless of handshake state.

## Test plan
- DIV_FACTOR=4, DUTY_MAX=10, STEP=3, HOLD_STEPS=2, ready=1, en=1 → duty_out sequence 3,6,9,10,10,10,7,4,1,0,0,0,3…; one value per 4 cycles; phase 1,1,1,2,2,3… (RISE→HOLD_HI on the 10 step).
- Same params, HOLD_STEPS=0 → 3,6,9,10,7,4,1,0,3…; phase never 2 or 4.
- ready held 0 for 6 ticks after value 3 → duty_out stays 3, duty_valid=1, overrun=1 from the second blocked tick. When ready returns: next value 6 (one buffered step), not 9+.
- ready pulsed every 8 cycles with DIV_FACTOR=4 → each pulse drains one value; overrun asserts at the first tick that finds pend=1.
- en dropped mid-FALL (duty 7), ready=1 → next cycle phase=0, duty_out=0, duty_valid=1. After accept, duty_valid=0. Re-enable → phase=1, first value 3 after 4 cycles.
- rst asserted while duty_valid=1 and ready=0 → next cycle duty_out=0, duty_valid=0, phase=0, overrun=0.
